t_table_reader: RTL

- Read-side counterpart of the T(nu, i) accumulator.
- The accumulator writes NU_VALUES running-sum columns per address into BRAM. This block reads a requested address range back out of that BRAM, honouring the BRAM's fixed read latency.
- It streams the entries to the downstream nu-search stage over a valid/ready interface with full backpressure support.

---
 rtl/t_pkg.sv | 27 ++
 rtl/t_reader_fifo.sv | 65 ++++++
 rtl/t_table_reader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/t_pkg.sv
// Shared types and sizing for the T(nu, i) table reader.
// All widths derive from the table geometry declared here.
package t_pkg;

  localparam int BIT_WIDTH    = 32;
  localparam int I            = 160;
  localparam int NU_VALUES    = 3;
  localparam int BRAM_LATENCY = 2;
  localparam int ADDR_W       = $clog2(I);
  localparam int CNT_W        = $clog2(I) + 1;
  localparam int FIFO_DEPTH   = BRAM_LATENCY + 2;
  localparam int FIFO_CNT_W   = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  typedef struct packed {
    logic [NU_VALUES*BIT_WIDTH-1:0] data;
    logic [ADDR_W-1:0]              index;
    logic                           last;
  } fifo_entry_t;

  // Table addresses wrap from I-1 back to 0.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(I - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/t_reader_fifo.sv
// Show-ahead synchronous FIFO: head_out always presents the oldest entry.
// Storage is cleared on reset so the head reads as zero when empty.
module t_reader_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] push_data_in,
  input  logic             pop_in,
  output logic [WIDTH-1:0] head_out,
  output logic             empty_out,
  output logic [CNT_W-1:0] count_out
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full FIFO can still accept a push when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop_in && (count_q != '0);
    do_push  = push_in && ((count_q != CNT_W'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_in;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_out  = mem_q[rd_ptr_q];
  assign empty_out = (count_q == '0);
  assign count_out = count_q;

endmodule

// File: rtl/t_table_reader.sv
// Reads an address range of the T(nu, i) BRAM and streams the packed columns
// downstream over valid/ready, issuing reads only when the FIFO has room.
module t_table_reader
  import t_pkg::*;
(
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           start_in,
  input  logic [ADDR_W-1:0]              first_addr_in,
  input  logic [CNT_W-1:0]               count_in,
  output logic                           bram_en_out,
  output logic [ADDR_W-1:0]              bram_addr_out,
  input  logic [NU_VALUES*BIT_WIDTH-1:0] bram_dout_in,
  output logic [BIT_WIDTH-1:0]           t_data_0_out,
  output logic [BIT_WIDTH-1:0]           t_data_1_out,
  output logic [BIT_WIDTH-1:0]           t_data_2_out,
  output logic [ADDR_W-1:0]              t_index_out,
  output logic                           t_last_out,
  output logic                           t_valid_out,
  input  logic                           t_ready_in,
  output logic                           busy_out,
  output logic                           done_out
);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [CNT_W-1:0]        remaining_q, remaining_d;
  logic                    done_q, done_d;
  logic [BRAM_LATENCY-1:0] vl_q, vl_d;
  logic [BRAM_LATENCY-1:0] pipe_last_q, pipe_last_d;
  logic [ADDR_W-1:0]       pipe_addr_q [BRAM_LATENCY];
  logic [ADDR_W-1:0]       pipe_addr_d [BRAM_LATENCY];
  logic [FIFO_CNT_W-1:0]   fifo_count, in_flight, outstanding;
  logic                    issue, fifo_empty, pop, accept_last;
  fifo_entry_t             push_entry, head;

  // Credit: every read in flight already owns a FIFO slot.
  always_comb begin
    in_flight = '0;
    for (int k = 0; k < BRAM_LATENCY; k++) begin
      in_flight = in_flight + FIFO_CNT_W'(vl_q[k]);
    end
    outstanding = fifo_count + in_flight;
    issue       = (state_q == ISSUE) && (outstanding < FIFO_CNT_W'(FIFO_DEPTH));
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        // A start landing on the done pulse belongs to the finished request.
        if (start_in && !done_q) begin
          if (count_in == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = first_addr_in;
            remaining_d = (count_in > CNT_W'(I)) ? CNT_W'(I) : count_in;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_d      = next_addr(addr_q);
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (accept_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vl_d           = '0;
    pipe_last_d    = '0;
    pipe_addr_d    = pipe_addr_q;
    vl_d[0]        = issue;
    pipe_addr_d[0] = addr_q;
    pipe_last_d[0] = (remaining_q == CNT_W'(1));
    for (int k = 1; k < BRAM_LATENCY; k++) begin
      vl_d[k]        = vl_q[k-1];
      pipe_addr_d[k] = pipe_addr_q[k-1];
      pipe_last_d[k] = pipe_last_q[k-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      vl_q        <= '0;
      pipe_last_q <= '0;
      pipe_addr_q <= '{default: '0};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      vl_q        <= vl_d;
      pipe_last_q <= pipe_last_d;
      pipe_addr_q <= pipe_addr_d;
    end
  end

  assign push_entry = '{data:  bram_dout_in,
                        index: pipe_addr_q[BRAM_LATENCY-1],
                        last:  pipe_last_q[BRAM_LATENCY-1]};

  t_reader_fifo #(
    .WIDTH($bits(fifo_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .push_in     (vl_q[BRAM_LATENCY-1]),
    .push_data_in(push_entry),
    .pop_in      (pop),
    .head_out    (head),
    .empty_out   (fifo_empty),
    .count_out   (fifo_count)
  );

  assign t_valid_out   = !fifo_empty;
  assign pop           = t_valid_out && t_ready_in;
  assign accept_last   = pop && head.last;
  assign t_data_0_out  = head.data[0*BIT_WIDTH +: BIT_WIDTH];
  assign t_data_1_out  = head.data[1*BIT_WIDTH +: BIT_WIDTH];
  assign t_data_2_out  = head.data[2*BIT_WIDTH +: BIT_WIDTH];
  assign t_index_out   = head.index;
  assign t_last_out    = head.last && t_valid_out;
  assign bram_en_out   = issue;
  assign bram_addr_out = addr_q;
  assign busy_out      = (state_q != IDLE);
  assign done_out      = done_q;

endmodule
